mandelbrot_iter_engine: RTL
===========================

MANDELBROT_ITER_ENGINE -- requirements
Module: mandelbrot_iter_engine

Interface
REQ-001 SHALL have parameter RESX, default 640, meaning horizontal resolution in pixels; xin values are 0..RESX-1.
REQ-002 SHALL have parameter RESY, default 480, meaning vertical resolution in pixels; yin values are 0..RESY-1.
REQ-003 SHALL have parameter WIDTH, default 32, meaning signed fixed-point word width.
REQ-004 SHALL have parameter FRAC, default 28, meaning fractional bits; WIDTH-FRAC SHALL be at least 4.
REQ-005 SHALL have parameter STAGES, default 4, meaning ring depth in register stages and also the number of pixels in flight.
REQ-006 SHALL have parameter MAX_ITER, default 256, meaning the iteration cap; it fits in 16 bits.
REQ-007 SHALL have parameters XMIN, YMIN, XSTEP, YSTEP, defaults -2.0, -1.5, 3.0/RESX, 3.0/RESY in FRAC format, meaning plane origin and per-pixel step.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port in_valid, input, 1 bit: a pixel is offered on xin/yin.
REQ-011 SHALL have port in_ready, output, 1 bit: the engine accepts the offered pixel this cycle.
REQ-012 SHALL have ports xin and yin, input, 11 bits each: pixel coordinates.
REQ-013 SHALL have port out_valid, output, 1 bit: a result is held on xout/yout/i.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-015 SHALL have ports xout and yout, output, 11 bits each: coordinate tag of the result.
REQ-016 SHALL have port i, output, 16 bits: iteration count of the result.
REQ-017 SHALL have ports jx and jy, input, WIDTH bits, present only with MANDELBROT_JULIA_EN: the Julia constant.

Function
REQ-018 SHALL map each pixel as cx = XMIN + xin*XSTEP and cy = YMIN + yin*YSTEP, signed, truncated to WIDTH bits.
REQ-019 SHALL hold per slot: valid, done, xin/yin tag, cx, cy, zx, zy and a 16-bit n; slots circulate through STAGES registers, and the head is stage STAGES-1.
REQ-020 SHALL evaluate the head slot each cycle: if zx²+zy² > 4.0, the slot becomes done with i=n; otherwise, if n==MAX_ITER, it becomes done with i=MAX_ITER; otherwise it computes z' = (zx²-zy²+cx, 2·zx·zy+cy) and n' = n+1.
REQ-021 SHALL form products at 2·WIDTH bits, shift them right by FRAC, and evaluate the escape compare at full precision with no overflow.
REQ-022 SHALL retire a done head slot into the output register when out_valid==0, or when out_valid && out_ready in that cycle.
REQ-023 SHALL recirculate a done head slot that cannot retire with z and n frozen, and retry it on its next arrival.
REQ-024 SHALL drive in_ready combinationally as 1 when the head slot is invalid or is retiring this cycle.
REQ-025 SHALL, on in_valid && in_ready, load the pixel into stage 0 with z=0 and n=0; retire and admit in the same cycle are legal.
REQ-026 SHALL keep xout, yout and i stable while out_valid && !out_ready.
REQ-027 SHALL allow results to retire out of order; the xout/yout tags identify each pixel.
REQ-028 SHALL, with no back-pressure, raise out_valid exactly STAGES·(i+1) cycles after the admission edge.
REQ-029 SHALL never drop or duplicate a pixel under any out_ready pattern.

Reset
REQ-030 SHALL, while rst is high, clear every slot valid and done bit, and force out_valid=0 and xout=yout=i=0.
REQ-031 SHALL discard in-flight pixels when rst is asserted mid-operation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-032 SHALL, with MANDELBROT_JULIA_EN defined, add jx/jy, load the admitted slot with z=(cx,cy), and use (jx,jy) as the additive constant.
REQ-033 SHALL, without MANDELBROT_JULIA_EN, omit jx/jy and operate as the Mandelbrot set per REQ-020/025.

Verification
REQ-034 SHALL cover RESX=RESY=16, XSTEP=YSTEP=0.25, STAGES=4, MAX_ITER=16 with out_ready=1: pixel (0,0), c=(-2,-1.5) -> i=1, out_valid at admission+8.
REQ-035 SHALL cover pixel (12,6), c=(1,0) -> i=3, out_valid at admission+16.
REQ-036 SHALL cover pixels (8,6) and (4,6), c=0 and c=(-1,0) -> i=16 for each.
REQ-037 SHALL cover four pixels (12,6),(0,0),(8,6),(12,6) back-to-back -> in_ready=0 on the fifth cycle, and (0,0) retires before the first (12,6).
REQ-038 SHALL cover out_ready=0 for 20 cycles with two done pixels -> one result held stable, the other recirculates, and both are delivered once after release.
REQ-039 SHALL cover rst pulsed with 3 pixels in flight -> no out_valid afterward, and in_ready=1 on the cycle after release.

Source files
------------

// File: rtl/mandelbrot_iter_engine.sv
// Mandelbrot/Julia escape-time engine: STAGES-deep ring of pixel slots, one z^2+c step per slot arrival at the head.
// Latency: STAGES*(i+1) cycles from admission edge to out_valid when the consumer never stalls.
// Backpressure: a finished head that cannot retire recirculates frozen; in_ready drops while a live head is not retiring.
// Build option: define MANDELBROT_JULIA_EN to add jx/jy and iterate the Julia set with z0 = c.
module mandelbrot_iter_engine #(
    parameter int     RESX     = 640,
    parameter int     RESY     = 480,
    parameter int     WIDTH    = 32,
    parameter int     FRAC     = 28,
    parameter int     STAGES   = 4,
    parameter int     MAX_ITER = 256,
    parameter longint XMIN     = -(longint'(2) <<< FRAC),
    parameter longint YMIN     = -(longint'(3) <<< (FRAC - 1)),
    parameter longint XSTEP    = (longint'(3) <<< FRAC) / RESX,
    parameter longint YSTEP    = (longint'(3) <<< FRAC) / RESY
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [10:0]             xin,
    input  logic [10:0]             yin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [10:0]             xout,
    output logic [10:0]             yout,
    output logic [15:0]             i
`ifdef MANDELBROT_JULIA_EN
    ,
    input  logic signed [WIDTH-1:0] jx,
    input  logic signed [WIDTH-1:0] jy
`endif
);

    localparam int PW = 2 * WIDTH;
    // 4.0 expressed at the 2*FRAC scale of an unshifted product
    localparam logic [PW:0] ESC_LIM = (PW + 1)'(1) << (2 * FRAC + 2);

    typedef struct packed {
        logic                    vld;
        logic                    done;
        logic [10:0]             x;
        logic [10:0]             y;
        logic signed [WIDTH-1:0] cx;
        logic signed [WIDTH-1:0] cy;
        logic signed [WIDTH-1:0] zx;
        logic signed [WIDTH-1:0] zy;
        logic [15:0]             n;
    } slot_t;

    slot_t                   r_ring [STAGES];
    slot_t                   w_head;
    slot_t                   w_s0;

    logic signed [WIDTH-1:0] w_cx;
    logic signed [WIDTH-1:0] w_cy;
    logic signed [WIDTH-1:0] w_add_x;
    logic signed [WIDTH-1:0] w_add_y;
    logic signed [WIDTH-1:0] w_zx_next;
    logic signed [WIDTH-1:0] w_zy_next;
    logic signed [PW-1:0]    w_zx2;
    logic signed [PW-1:0]    w_zy2;
    logic signed [PW-1:0]    w_zxzy;
    logic [PW:0]             w_mag;
    logic                    w_escape;
    logic                    w_at_cap;
    logic                    w_head_done;
    logic                    w_retire;

    logic                    r_out_valid;
    logic [10:0]             r_xout;
    logic [10:0]             r_yout;
    logic [15:0]             r_i;

    assign w_head = r_ring[STAGES-1];

    // Pixel to plane mapping, done in 64-bit then truncated to the word width
    assign w_cx = WIDTH'(XMIN + $signed({53'd0, xin}) * XSTEP);
    assign w_cy = WIDTH'(YMIN + $signed({53'd0, yin}) * YSTEP);

`ifdef MANDELBROT_JULIA_EN
    assign w_add_x = jx;
    assign w_add_y = jy;
`else
    assign w_add_x = w_head.cx;
    assign w_add_y = w_head.cy;
`endif

    // Full-width products; the magnitude test uses them unshifted so it never overflows
    assign w_zx2    = $signed(w_head.zx) * $signed(w_head.zx);
    assign w_zy2    = $signed(w_head.zy) * $signed(w_head.zy);
    assign w_zxzy   = $signed(w_head.zx) * $signed(w_head.zy);
    assign w_mag    = {1'b0, w_zx2} + {1'b0, w_zy2};
    assign w_escape = w_mag > ESC_LIM;
    assign w_at_cap = w_head.n == 16'(MAX_ITER);

    // Each product is rescaled on its own; 2*zx*zy folds the doubling into a one-shorter shift
    assign w_zx_next = WIDTH'(w_zx2 >>> FRAC) - WIDTH'(w_zy2 >>> FRAC) + w_add_x;
    assign w_zy_next = WIDTH'(w_zxzy >>> (FRAC - 1)) + w_add_y;

    // A done head carries its final count in n, so the result is always n
    assign w_head_done = w_head.vld && (w_head.done || w_escape || w_at_cap);
    assign w_retire    = w_head_done && (!r_out_valid || out_ready);
    assign in_ready    = !w_head.vld || w_retire;

    // Stage-0 source: a newly admitted pixel when the head slot frees up, else the head itself
    always_comb begin
        w_s0 = '0;
        if (in_ready) begin
            if (in_valid) begin
                w_s0.vld = 1'b1;
                w_s0.x   = xin;
                w_s0.y   = yin;
                w_s0.cx  = w_cx;
                w_s0.cy  = w_cy;
`ifdef MANDELBROT_JULIA_EN
                w_s0.zx  = w_cx;
                w_s0.zy  = w_cy;
`endif
            end
        end else begin
            w_s0 = w_head;
            if (!w_head.done) begin
                if (w_escape || w_at_cap) begin
                    w_s0.done = 1'b1;
                end else begin
                    w_s0.zx = w_zx_next;
                    w_s0.zy = w_zy_next;
                    w_s0.n  = w_head.n + 16'd1;
                end
            end
        end
    end

    // Ring rotation: stage k feeds k+1, the head wraps back through stage 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ring[k] <= '0;
            end
        end else begin
            r_ring[0] <= w_s0;
            for (int k = 1; k < STAGES; k++) begin
                r_ring[k] <= r_ring[k-1];
            end
        end
    end

    // Output holding register: loads on retire, otherwise drains on a consumer handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_xout      <= '0;
            r_yout      <= '0;
            r_i         <= '0;
        end else if (w_retire) begin
            r_out_valid <= 1'b1;
            r_xout      <= w_head.x;
            r_yout      <= w_head.y;
            r_i         <= w_head.n;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign xout      = r_xout;
    assign yout      = r_yout;
    assign i         = r_i;

endmodule
